// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus port between the IF and MEM requesters,
// issuing at most one transaction per requester per pipeline advance.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                IF_DONE,
  input  logic                mem_req,
  input  logic [DATA_W/8-1:0] mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                MEM_DONE,
  input  logic                pipe_adv,
  output logic                bus_req,
  output logic [DATA_W/8-1:0] bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;
  state_t              state_q;
  logic                own_if_q, if_cmpl_q, mem_cmpl_q, bus_req_q;
  logic [DATA_W/8-1:0] bus_we_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic [DATA_W-1:0]   bus_wdata_q, if_rdata_q, mem_rdata_q;
  logic                if_elig, mem_elig, rd_q;
  // Arbitration only happens in IDLE, so nothing is in flight when eligibility is used
  assign if_elig   = if_req & ~if_cmpl_q;
  assign mem_elig  = mem_req & ~mem_cmpl_q;
  assign rd_q      = bus_we_q == '0;
  assign IF_DONE   = if_cmpl_q | ~if_req;
  assign MEM_DONE  = mem_cmpl_q | ~mem_req;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      own_if_q    <= 1'b0;
      if_cmpl_q   <= 1'b0;
      mem_cmpl_q  <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if (pipe_adv) begin
        if_cmpl_q  <= 1'b0;
        mem_cmpl_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (mem_elig || if_elig) begin
          own_if_q    <= ~mem_elig;
          bus_req_q   <= 1'b1;
          bus_addr_q  <= mem_elig ? mem_addr : if_addr;
          bus_we_q    <= mem_elig ? mem_we : '0;
          bus_wdata_q <= mem_elig ? mem_wdata : '0;
          state_q     <= ISSUE;
        end
        ISSUE: if (bus_gnt) begin
          bus_req_q <= 1'b0;
          state_q   <= WAIT_RESP;
        end
        WAIT_RESP: if (bus_rvalid) begin
          // Placed after the pipe_adv clear so a same-cycle completion wins
          if (own_if_q) if_cmpl_q <= 1'b1;
          else mem_cmpl_q <= 1'b1;
          if (own_if_q && rd_q) if_rdata_q <= bus_rdata;
          if (!own_if_q && rd_q) mem_rdata_q <= bus_rdata;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a
// transaction-level model of the per-advance service order and captured data.
module tb_mem_port_arbiter;
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst, if_req, mem_req, pipe_adv;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_we;
  logic        IF_DONE, MEM_DONE, bus_req, bus_gnt, bus_rvalid;
  logic        m_gnt, m_rvalid, r_gnt, r_rvalid, auto_en, rd_fixed;
  logic [31:0] m_rdata, r_rdata, rd_val;
  int          gnt_cfg, rsp_cfg, phase, cnt;
  int          checks = 0, failures = 0;
  txn_t        log_q[$];

  always #5 clk = ~clk;

  assign bus_gnt    = r_gnt | m_gnt;
  assign bus_rvalid = r_rvalid | m_rvalid;
  assign bus_rdata  = m_rvalid ? m_rdata : r_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .IF_DONE(IF_DONE),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .MEM_DONE(MEM_DONE), .pipe_adv(pipe_adv),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  // Memory model: grants after a configurable delay, logs every granted transaction,
  // then answers after a second delay; all driving and sampling happens on negedge.
  task automatic grant;
    r_gnt = 1'b1;
    log_q.push_back('{bus_addr, bus_we, bus_wdata, 32'h0});
    cnt   = rsp_cfg < 0 ? int'($urandom_range(0, 3)) : rsp_cfg;
    phase = 2;
  endtask

  initial begin
    r_gnt = 1'b0; r_rvalid = 1'b0; r_rdata = '0; phase = 0; cnt = 0;
    forever begin
      @(negedge clk);
      r_gnt = 1'b0;
      r_rvalid = 1'b0;
      if (auto_en) begin
        case (phase)
          0: if (bus_req) begin
            cnt = gnt_cfg < 0 ? int'($urandom_range(0, 3)) : gnt_cfg;
            if (cnt == 0) grant();
            else phase = 1;
          end
          1: begin
            cnt--;
            if (cnt == 0) grant();
          end
          2: if (cnt == 0) begin
            r_rvalid = 1'b1;
            r_rdata  = rd_fixed ? rd_val : $urandom;
            log_q[log_q.size()-1].rdata = r_rdata;
            phase = 0;
          end else cnt--;
          default: phase = 0;
        endcase
      end
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(IF_DONE && MEM_DONE) && n < 300);
    if (!(IF_DONE && MEM_DONE)) chk("done_timeout", 32'(IF_DONE & MEM_DONE), 32'd1);
  endtask

  task automatic adv_drop;
    pipe_adv = 1'b1;
    if_req   = 1'b0;
    mem_req  = 1'b0;
    tick();
    pipe_adv = 1'b0;
  endtask

  initial begin
    int n, base, md, id, exp_n;
    logic [31:0] exp_if, exp_mem;
    logic ir, mr, held;
    logic [3:0] mw;
    logic [31:0] ia, ma, wd;
    txn_t exp_q[$];
    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; pipe_adv = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; mem_we = '0;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    auto_en = 1'b1; rd_fixed = 1'b0; rd_val = '0; gnt_cfg = 0; rsp_cfg = 0;
    // Reset then idle
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_if_done", 32'(IF_DONE), 32'd1);
    chk("rst_mem_done", 32'(MEM_DONE), 32'd1);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    // IF read with delayed grant and response
    gnt_cfg = 2; rsp_cfg = 3; rd_fixed = 1'b1; rd_val = 32'hDEADBEEF;
    base = log_q.size();
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    chk("if_bus_req", 32'(bus_req), 32'd1);
    chk("if_bus_addr", bus_addr, 32'h100);
    chk("if_bus_we", 32'(bus_we), 32'd0);
    wait_done(n);
    chk("if_rdata", if_rdata, 32'hDEADBEEF);
    chk("if_done", 32'(IF_DONE), 32'd1);
    repeat (4) tick();
    chk("if_done_held", 32'(IF_DONE), 32'd1);
    chk("if_single_issue", 32'(log_q.size() - base), 32'd1);
    adv_drop();
    chk("if_rdata_after_adv", if_rdata, 32'hDEADBEEF);
    // Contention: MEM served first, each in the 3-cycle minimum
    gnt_cfg = 0; rsp_cfg = 0; rd_fixed = 1'b0;
    base = log_q.size();
    if_req = 1'b1; if_addr = 32'h200;
    mem_req = 1'b1; mem_we = 4'h0; mem_addr = 32'h8000; mem_wdata = 32'h0;
    md = -1; id = -1;
    for (int i = 1; i <= 20 && (md < 0 || id < 0); i++) begin
      tick();
      if (MEM_DONE && md < 0) md = i;
      if (IF_DONE && id < 0) id = i;
    end
    chk("cont_mem_done_cyc", 32'(md), 32'd3);
    chk("cont_if_done_cyc", 32'(id), 32'd6);
    chk("cont_txn_cnt", 32'(log_q.size() - base), 32'd2);
    if (log_q.size() - base == 2) begin
      chk("cont_first_addr", log_q[base].addr, 32'h8000);
      chk("cont_second_addr", log_q[base+1].addr, 32'h200);
      chk("cont_mem_rdata", mem_rdata, log_q[base].rdata);
      chk("cont_if_rdata", if_rdata, log_q[base+1].rdata);
      exp_mem = log_q[base].rdata;
    end else exp_mem = 32'h0;
    adv_drop();
    // MEM write leaves mem_rdata untouched
    gnt_cfg = 0; rsp_cfg = 1;
    base = log_q.size();
    mem_req = 1'b1; mem_we = 4'b0011; mem_addr = 32'h8004; mem_wdata = 32'h1234ABCD;
    tick();
    chk("wr_bus_we", 32'(bus_we), 32'h3);
    chk("wr_bus_addr", bus_addr, 32'h8004);
    chk("wr_bus_wdata", bus_wdata, 32'h1234ABCD);
    wait_done(n);
    chk("wr_mem_done", 32'(MEM_DONE), 32'd1);
    chk("wr_mem_rdata_kept", mem_rdata, exp_mem);
    chk("wr_txn_cnt", 32'(log_q.size() - base), 32'd1);
    adv_drop();
    // Flag hold while MEM grant is slow, then re-issue after advance
    gnt_cfg = 0; rsp_cfg = 0;
    base = log_q.size();
    if_req = 1'b1; if_addr = 32'h300;
    wait_done(n);
    gnt_cfg = 10;
    mem_req = 1'b1; mem_we = 4'h0; mem_addr = 32'h9000;
    held = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (!IF_DONE) held = 1'b0;
    end while (!MEM_DONE && n < 300);
    chk("hold_mem_done", 32'(MEM_DONE), 32'd1);
    chk("hold_if_done_held", 32'(held), 32'd1);
    chk("hold_txn_cnt", 32'(log_q.size() - base), 32'd2);
    gnt_cfg = 0;
    pipe_adv = 1'b1; mem_req = 1'b0; if_addr = 32'h304;
    tick();
    pipe_adv = 1'b0;
    chk("adv_clears_if", 32'(IF_DONE), 32'd0);
    wait_done(n);
    chk("reissue_txn_cnt", 32'(log_q.size() - base), 32'd3);
    if (log_q.size() - base == 3) chk("reissue_addr", log_q[base+2].addr, 32'h304);
    adv_drop();
    // Reset while waiting for the response; the late rvalid must be ignored
    auto_en = 1'b0;
    mem_req = 1'b1; mem_we = 4'h0; mem_addr = 32'hA000;
    tick();
    chk("rmid_bus_req", 32'(bus_req), 32'd1);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    chk("rmid_wait_bus_req", 32'(bus_req), 32'd0);
    rst = 1'b0;
    tick();
    chk("rmid_in_rst_bus_req", 32'(bus_req), 32'd0);
    rst = 1'b1; mem_req = 1'b0;
    tick();
    m_rvalid = 1'b1; m_rdata = 32'h5555AAAA;
    tick();
    m_rvalid = 1'b0;
    chk("rmid_mem_rdata", mem_rdata, 32'd0);
    chk("rmid_if_rdata", if_rdata, 32'd0);
    chk("rmid_bus_req_idle", 32'(bus_req), 32'd0);
    mem_req = 1'b1;
    tick();
    chk("rmid_no_flag", 32'(MEM_DONE), 32'd0);
    chk("rmid_new_issue", 32'(bus_req), 32'd1);
    rst = 1'b0; mem_req = 1'b0;
    tick(); tick();
    rst = 1'b1;
    // rvalid and pipe_adv in the same cycle: completion wins
    mem_req = 1'b1; mem_we = 4'h0; mem_addr = 32'hB000;
    tick();
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h77; pipe_adv = 1'b1;
    tick();
    m_rvalid = 1'b0; pipe_adv = 1'b0;
    chk("sim_mem_done", 32'(MEM_DONE), 32'd1);
    chk("sim_mem_rdata", mem_rdata, 32'h77);
    tick(); tick();
    chk("sim_no_reissue", 32'(bus_req), 32'd0);
    adv_drop();
    // Randomized advances against the per-advance service model
    auto_en = 1'b1; gnt_cfg = -1; rsp_cfg = -1; rd_fixed = 1'b0;
    exp_if = 32'h0; exp_mem = 32'h77;
    for (int it = 0; it < 40; it++) begin
      base = log_q.size();
      ir = 1'($urandom_range(0, 1)); mr = 1'($urandom_range(0, 1));
      ia = $urandom; ma = $urandom; wd = $urandom;
      mw = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      if_req = ir; if_addr = ia;
      mem_req = mr; mem_addr = ma; mem_we = mw; mem_wdata = wd;
      wait_done(n);
      exp_q.delete();
      if (mr) exp_q.push_back('{ma, mw, wd, 32'h0});
      if (ir) exp_q.push_back('{ia, 4'h0, 32'h0, 32'h0});
      exp_n = exp_q.size();
      chk("rnd_txn_cnt", 32'(log_q.size() - base), 32'(exp_n));
      if (log_q.size() - base == exp_n) begin
        foreach (exp_q[k]) begin
          chk("rnd_addr", log_q[base+k].addr, exp_q[k].addr);
          chk("rnd_we", 32'(log_q[base+k].we), 32'(exp_q[k].we));
          chk("rnd_wdata", log_q[base+k].wdata, exp_q[k].wdata);
        end
        if (mr && mw == 4'h0) exp_mem = log_q[base].rdata;
        if (ir) exp_if = log_q[base+exp_n-1].rdata;
      end
      chk("rnd_if_rdata", if_rdata, exp_if);
      chk("rnd_mem_rdata", mem_rdata, exp_mem);
      adv_drop();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one memory bus port between the instruction-fetch requester (IF) and the data-memory requester (MEM) of the 5-stage CPU. It issues at most one bus transaction per requester per pipeline advance and captures the read data. It produces the IF_DONE / MEM_DONE levels that gate the pipeline registers (IFID, MEMWB, ...). Each done flag and its captured data are held stable until the pipeline advances, so the early-finishing requester never re-issues.

Parameters:
ADDR_W, 32, bus/requester address width
DATA_W, 32, data width; byte strobe width is DATA_W/8

Ports:
clk        in   1         clock; all logic on posedge
rst        in   1         synchronous, active-low reset (0 = reset)
if_req     in   1         IF wants a read this pipeline cycle (level)
if_addr    in   ADDR_W    IF read address; stable while if_req=1
if_rdata   out  DATA_W    captured IF read data
IF_DONE    out  1         IF access complete, or no IF access requested
mem_req    in   1         MEM wants an access this pipeline cycle (level)
mem_we     in   DATA_W/8  byte write strobes; 0 = read
mem_addr   in   ADDR_W    MEM address
mem_wdata  in   DATA_W    MEM write data
mem_rdata  out  DATA_W    captured MEM read data
MEM_DONE   out  1         MEM access complete, or no MEM access requested
pipe_adv   in   1         pipeline advances this cycle (IF_DONE && MEM_DONE && no other stall)
bus_req    out  1         transaction valid toward memory
bus_we     out  DATA_W/8  write strobes of issued transaction
bus_addr   out  ADDR_W    address of issued transaction
bus_wdata  out  DATA_W    write data of issued transaction
bus_gnt    in   1         memory accepts request (sampled while bus_req=1)
bus_rvalid in   1         response (read data or write ack) valid
bus_rdata  in   DATA_W    response read data

Behaviour:
- Reset (rst=0 at posedge):
  - FSM to IDLE.
  - bus_req, bus_we, bus_addr, bus_wdata, if_rdata, mem_rdata all 0.
  - Completion flags if_cmpl and mem_cmpl cleared.
  - Owner register cleared to MEM.
- Done outputs (combinational):
  - IF_DONE = if_cmpl | ~if_req
  - MEM_DONE = mem_cmpl | ~mem_req
  - After reset with no requests, both are 1.
- A requester is eligible when its req=1, its cmpl=0, and it is not the current in-flight owner.
- FSM states:
  - IDLE:
    - If MEM is eligible, owner=MEM; else if IF is eligible, owner=IF.
    - MEM has fixed priority because it is the older instruction.
    - On selection, register bus_addr/bus_we/bus_wdata from the owner (IF: we=0, wdata=0), set bus_req=1, go to ISSUE.
    - Otherwise stay in IDLE with bus_req=0.
    - Latency: the request is seen at edge N, and bus_req is high from cycle N+1.
  - ISSUE:
    - Hold bus_req and the payload stable until bus_gnt=1.
    - On gnt: bus_req=0 next cycle, go to WAIT_RESP.
    - No limit on gnt wait.
  - WAIT_RESP:
    - On bus_rvalid: set the owner's cmpl flag.
    - For a read (bus_we==0), capture bus_rdata into the owner's rdata register. Writes leave that register unchanged.
    - Go to IDLE. The next arbitration happens in the following cycle.
- bus_rvalid outside WAIT_RESP is ignored, including a same-cycle rvalid in ISSUE.
- Minimum access: 3 cycles from req to DONE when gnt and rvalid are both immediate.
- pipe_adv:
  - Clears if_cmpl and mem_cmpl.
  - Does not affect the FSM; an in-flight transaction continues to completion.
  - If rvalid sets a flag in the same cycle pipe_adv clears it, the set wins.
- if_rdata and mem_rdata change only on their own read completion; they are held across pipe_adv.
- A requester dropping req while in flight does not abort the transaction. Its completion is still recorded, and the data is captured for reads.
- With both requesters pending each cycle, service order per advance is MEM then IF. Neither is served twice before pipe_adv.
- Reset mid-operation (any state): immediate return to IDLE with the reset values above. A late bus_rvalid from the aborted access is ignored because the FSM is in IDLE.

Test Plan:
- Reset, then idle: rst=0 for 2 cycles, then rst=1 with no requests -> all bus outputs 0, IF_DONE=1, MEM_DONE=1, rdata outputs 0.
- IF read:
  - Stimulus: if_req=1, if_addr=0x100, gnt 2 cycles after bus_req, rvalid 3 cycles after gnt with rdata=0xDEADBEEF.
  - Required: bus_addr=0x100, bus_we=0; if_rdata=0xDEADBEEF and IF_DONE=1 the cycle after rvalid, held until pipe_adv.
- Contention:
  - Stimulus: if_req=1 (0x200) and mem_req=1 (read 0x8000) in the same cycle, immediate gnt/rvalid.
  - Required: bus_addr sequence is 0x8000 then 0x200; MEM_DONE rises before IF_DONE.
- MEM write:
  - Stimulus: mem_we=4'b0011, mem_addr=0x8004, mem_wdata=0x1234ABCD.
  - Required: bus shows the same values; MEM_DONE=1 after rvalid; mem_rdata unchanged.
- Flag hold and advance:
  - Stimulus: IF completes while the MEM gnt is delayed 10 cycles.
  - Required: no second IF bus_req; IF_DONE held at 1; pipe_adv after MEM completes clears both flags; the next if_req is re-issued.
- Reset mid-operation:
  - Stimulus: rst=0 in WAIT_RESP, then rvalid arrives 1 cycle after release.
  - Required: the FSM is in IDLE, no flag is set, and rdata stays 0.
- Simultaneous events: pipe_adv in the same cycle as an rvalid for the owner -> the owner's cmpl flag ends at 1.
